apb_timer: RTL and testbench
============================

# apb_timer

APB peripheral that sits directly downstream of the AHB-to-APB bridge on one of its three `Pselx` lines. It decodes single-cycle-setup/single-cycle-enable APB transfers with zero wait states and returns read data on `Prdata`. It contains a 32-bit down-counter with an optional 8-bit prescaler, one-shot/periodic modes and a level interrupt. It is the first real slave used to exercise the bridge end to end.

## Interface
- `RESET_LOAD`, default 32'hFFFF_FFFF: reset value of LOAD and VALUE.
- `Hclk` input 1: bridge clock, all state on rising edge.
- `Hresetn` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `Psel` input 1: this slave's bit of bridge `Pselx`.
- `Penable` input 1: APB enable phase.
- `Pwrite` input 1: 1 = write, 0 = read.
- `Paddr` input 32: only `[3:2]` decoded; `[31:4]`, `[1:0]` ignored.
- `Pwdata` input 32: write data.
- `Prdata` output 32: read data.
- `Irq` output 1: registered interrupt, `EXPIRED & IE`.

## Operation
- Registers, selected by `Paddr[3:2]`:
  - 0 CTRL: `[0]` EN, `[1]` PERIODIC, `[2]` IE, `[15:8]` PRESCALE. Other bits read 0.
  - 1 LOAD: R/W.
  - 2 VALUE: read-only; writes ignored.
  - 3 STATUS: `[0]` EXPIRED; writing 1 clears it, writing 0 has no effect.
- Write commit: `Psel & Penable & Pwrite` at a rising edge. A setup-phase-only cycle has no effect.
- A LOAD write also copies `Pwdata` into VALUE and clears the prescaler count.
- A CTRL write clears the prescaler count.
- Read: `Prdata` is combinational from the addressed register while `Psel & !Pwrite`; otherwise 32'h0. Valid in both setup and enable phases. Reads have no side effects.
- Prescaler: counts 0..PRESCALE while EN=1 and produces a one-cycle `tick` when count == PRESCALE, then wraps to 0. A tick therefore occurs every PRESCALE+1 cycles. It holds at 0 while EN=0.
- Counter states: IDLE (EN=0), RUN (EN=1).
  - On tick in RUN with VALUE>1: VALUE decrements.
  - On tick in RUN with VALUE==1: EXPIRED is set. If PERIODIC, VALUE<=LOAD. Otherwise VALUE<=0 and EN<=0 (one-shot, returns to IDLE).
  - On tick in RUN with VALUE==0 (LOAD=0 written): treated as VALUE==1.
- Simultaneous events:
  - An APB write to LOAD or CTRL in the same cycle as a tick: the write wins and the tick is discarded.
  - A STATUS write-1-clear in the same cycle as expiry: set wins and EXPIRED stays 1.
- Reset values: CTRL=0, LOAD=VALUE=`RESET_LOAD`, EXPIRED=0, prescaler=0, `Irq`=0. `Prdata` is 0 unless selected.
- Reset asserted mid-count returns all state to reset values immediately. No transfer completes.

## Timing
- Zero wait states. The bridge has no PREADY; every access completes in 2 cycles (setup + enable).
- Write-to-effect latency: the new register value is visible to a read starting the next cycle.
- VALUE reaches 1→expiry on the tick edge. EXPIRED is visible the following cycle, and `Irq` one cycle after EXPIRED (registered).
- With PRESCALE=0 and EN set at edge N, the first decrement happens at edge N+1.

## Configuration
- `APB_TIMER_PRESCALE_EN`:
  - Defined: the 8-bit prescaler and the CTRL`[15:8]` field exist as above.
  - Undefined: no prescaler logic. The tick is constant 1 while EN=1. CTRL`[15:8]` is write-ignored and reads 0.

## Structure
- Shared package `bridge_pkg` holds:
  - register offsets (`TMR_CTRL`=2'd0, `TMR_LOAD`=2'd1, `TMR_VALUE`=2'd2, `TMR_STATUS`=2'd3);
  - CTRL bit positions and the PRESCALE field range;
  - the STATUS EXPIRED bit.
- One sub-module, `apb_timer_prescaler` (EN, PRESCALE, clear → tick), instantiated only under `APB_TIMER_PRESCALE_EN`.

## Test plan
- Reset, then read all four offsets → CTRL=0, LOAD=VALUE=32'hFFFF_FFFF, STATUS=0, `Irq`=0.
- Write LOAD=5, CTRL=32'h5 (EN, IE, PRESCALE 0) → VALUE reads 4,3,2,1 on successive cycles. EXPIRED=1, EN=0, VALUE=0 and `Irq`=1 one cycle later.
- Write LOAD=3, CTRL=32'h0000_0303 (EN, PERIODIC, PRESCALE 3) → one decrement per 4 cycles, expiry every 12 cycles, VALUE reloads to 3.
- Write STATUS=1 on the exact expiry cycle → EXPIRED stays 1. Write STATUS=1 one cycle later → EXPIRED=0 and `Irq` drops the next cycle.
- LOAD write of 32'h10 coinciding with a tick → VALUE=32'h10, no decrement that cycle. A VALUE write of 32'h99 is ignored.
- Assert `Hresetn` low mid-count (VALUE=7) → all registers return to reset values asynchronously. After release, `Prdata`=0 with `Psel`=0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge-attached APB timer: register offsets,
// CTRL/STATUS bit positions and the FSM state encoding.
package bridge_pkg;

   localparam logic [1:0] TMR_CTRL   = 2'd0;
   localparam logic [1:0] TMR_LOAD   = 2'd1;
   localparam logic [1:0] TMR_VALUE  = 2'd2;
   localparam logic [1:0] TMR_STATUS = 2'd3;

   localparam int CTRL_EN_BIT        = 0;
   localparam int CTRL_PERIODIC_BIT  = 1;
   localparam int CTRL_IE_BIT        = 2;
   localparam int CTRL_PRESCALE_LSB  = 8;
   localparam int CTRL_PRESCALE_MSB  = 15;

   localparam int STATUS_EXPIRED_BIT = 0;

   typedef enum logic {
      TMR_IDLE = 1'b0,
      TMR_RUN  = 1'b1
   } tmr_state_e;

   // Assembles the CTRL read image; unused bits read as zero.
   function automatic logic [31:0] ctrl_pack(input logic en, input logic periodic,
                                             input logic ie, input logic [7:0] prescale);
      logic [31:0] v;
      v = '0;
      v[CTRL_EN_BIT]                             = en;
      v[CTRL_PERIODIC_BIT]                       = periodic;
      v[CTRL_IE_BIT]                             = ie;
      v[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB]     = prescale;
      return v;
   endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB slave-side bus bundle between the AHB-to-APB bridge and the timer.
interface apb_timer_if;
   logic        Psel;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;

   modport master (output Psel, Penable, Pwrite, Paddr, Pwdata, input  Prdata);
   modport slave  (input  Psel, Penable, Pwrite, Paddr, Pwdata, output Prdata);
endinterface

// File: rtl/apb_timer_prescaler.sv
// 8-bit prescaler: counts 0..i_prescale while enabled and emits a one-cycle tick
// on the terminal count; i_clear restarts the count from 0.
module apb_timer_prescaler (
   input  logic       Hclk,
   input  logic       Hresetn,
   input  logic       i_en,
   input  logic       i_clear,
   input  logic [7:0] i_prescale,
   output logic       o_tick
);
   logic [7:0] r_count;
   logic       w_terminal;

   assign w_terminal = (r_count == i_prescale);
   assign o_tick     = i_en & w_terminal;

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_count <= 8'h00;
      end else if (i_clear || !i_en || w_terminal) begin
         r_count <= 8'h00;
      end else begin
         r_count <= r_count + 8'd1;
      end
   end
endmodule

// File: rtl/apb_timer.sv
// APB timer: 32-bit down-counter with one-shot/periodic modes and registered IRQ.
// The 8-bit prescaler and CTRL[15:8] exist only when APB_TIMER_PRESCALE_EN is defined.
module apb_timer
   import bridge_pkg::*;
#(
   parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
   input  logic       Hclk,
   input  logic       Hresetn,
   apb_timer_if.slave apb,
   output logic       Irq
);
   tmr_state_e  r_state;
   tmr_state_e  w_state_nxt;
   logic        r_periodic;
   logic        r_ie;
   logic        r_expired;
   logic        r_irq;
   logic [31:0] r_load;
   logic [31:0] r_value;
   logic [31:0] w_value_nxt;
   logic        w_expired_nxt;
   logic [31:0] w_rdata;
   logic        w_wr;
   logic        w_wr_ctrl;
   logic        w_wr_load;
   logic        w_wr_status;
   logic        w_clr_ps;
   logic        w_run;
   logic        w_tick;
   logic        w_tick_run;
   logic        w_expire;
   logic [7:0]  w_prescale_rd;
   logic        w_unused_bits;

   assign w_wr        = apb.Psel & apb.Penable & apb.Pwrite;
   assign w_wr_ctrl   = w_wr & (apb.Paddr[3:2] == TMR_CTRL);
   assign w_wr_load   = w_wr & (apb.Paddr[3:2] == TMR_LOAD);
   assign w_wr_status = w_wr & (apb.Paddr[3:2] == TMR_STATUS);
   assign w_clr_ps    = w_wr_ctrl | w_wr_load;
   assign w_run       = (r_state == TMR_RUN);

   assign w_unused_bits = ^{apb.Paddr[31:4], apb.Paddr[1:0]};

`ifdef APB_TIMER_PRESCALE_EN
   logic [7:0] r_prescale;

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_prescale <= 8'h00;
      end else if (w_wr_ctrl) begin
         r_prescale <= apb.Pwdata[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
      end
   end

   apb_timer_prescaler u_prescaler (
      .Hclk       (Hclk),
      .Hresetn    (Hresetn),
      .i_en       (w_run),
      .i_clear    (w_clr_ps),
      .i_prescale (r_prescale),
      .o_tick     (w_tick)
   );

   assign w_prescale_rd = r_prescale;
`else
   assign w_tick        = w_run;
   assign w_prescale_rd = 8'h00;
`endif

   // A LOAD/CTRL write in the same cycle swallows the tick.
   assign w_tick_run = w_tick & w_run & ~w_clr_ps;
   // VALUE==0 (after LOAD=0) expires exactly like VALUE==1.
   assign w_expire   = w_tick_run & (r_value <= 32'd1);

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_state <= TMR_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_wr_ctrl) begin
         w_state_nxt = apb.Pwdata[CTRL_EN_BIT] ? TMR_RUN : TMR_IDLE;
      end else if (w_expire && !r_periodic) begin
         w_state_nxt = TMR_IDLE;
      end
   end

   always_comb begin
      w_value_nxt = r_value;
      if (w_wr_load) begin
         w_value_nxt = apb.Pwdata;
      end else if (w_expire) begin
         w_value_nxt = r_periodic ? r_load : 32'h0;
      end else if (w_tick_run) begin
         w_value_nxt = r_value - 32'd1;
      end

      // Expiry beats a simultaneous write-1-to-clear.
      w_expired_nxt = r_expired;
      if (w_expire) begin
         w_expired_nxt = 1'b1;
      end else if (w_wr_status && apb.Pwdata[STATUS_EXPIRED_BIT]) begin
         w_expired_nxt = 1'b0;
      end
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_periodic <= 1'b0;
         r_ie       <= 1'b0;
         r_load     <= RESET_LOAD;
         r_value    <= RESET_LOAD;
         r_expired  <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr_ctrl) begin
            r_periodic <= apb.Pwdata[CTRL_PERIODIC_BIT];
            r_ie       <= apb.Pwdata[CTRL_IE_BIT];
         end
         if (w_wr_load) begin
            r_load <= apb.Pwdata;
         end
         r_value   <= w_value_nxt;
         r_expired <= w_expired_nxt;
         r_irq     <= r_expired & r_ie;
      end
   end

   always_comb begin
      w_rdata = 32'h0;
      if (apb.Psel && !apb.Pwrite) begin
         case (apb.Paddr[3:2])
            TMR_CTRL:   w_rdata = ctrl_pack(w_run, r_periodic, r_ie, w_prescale_rd);
            TMR_LOAD:   w_rdata = r_load;
            TMR_VALUE:  w_rdata = r_value;
            TMR_STATUS: w_rdata = {31'h0, r_expired};
            default:    w_rdata = 32'h0;
         endcase
      end
   end

   assign apb.Prdata = w_rdata;
   assign Irq        = r_irq;
endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: register table plus cycle-exact timer sequences.
// Expectations adapt to whether APB_TIMER_PRESCALE_EN is defined.
module tb_apb_timer;
`ifdef APB_TIMER_PRESCALE_EN
   localparam int PS     = 3;
   localparam bit HAS_PS = 1'b1;
`else
   localparam int PS     = 0;
   localparam bit HAS_PS = 1'b0;
`endif
   localparam int P = PS + 1;

   localparam logic [31:0] A_CTRL   = 32'h0;
   localparam logic [31:0] A_LOAD   = 32'h4;
   localparam logic [31:0] A_VALUE  = 32'h8;
   localparam logic [31:0] A_STATUS = 32'hC;

   logic Hclk    = 1'b0;
   logic Hresetn = 1'b0;
   logic Irq;

   apb_timer_if bus ();

   apb_timer #(.RESET_LOAD(32'hFFFF_FFFF)) dut (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .apb     (bus),
      .Irq     (Irq)
   );

   always #5 Hclk = ~Hclk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      string       name;
   } vec_t;
   vec_t tbl[16];

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.Psel    = 1'b0;
      bus.Penable = 1'b0;
      bus.Pwrite  = 1'b0;
      bus.Paddr   = 32'h0;
      bus.Pwdata  = 32'h0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge Hclk);
      #1;
   endtask

   // Setup-phase read: Prdata is combinational, so no clock edge is consumed.
   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      sb_t e;
      sb.push_back('{name, exp});
      bus.Psel    = 1'b1;
      bus.Penable = 1'b0;
      bus.Pwrite  = 1'b0;
      bus.Paddr   = addr;
      #1;
      e = sb.pop_front();
      compare(e.name, bus.Prdata, e.exp);
      idle();
   endtask

   // Commits on the second rising edge after the call.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.Psel    = 1'b1;
      bus.Penable = 1'b0;
      bus.Pwrite  = 1'b1;
      bus.Paddr   = addr;
      bus.Pwdata  = data;
      @(posedge Hclk);
      #1 bus.Penable = 1'b1;
      @(posedge Hclk);
      #1 idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   initial begin
      tbl = '{
         '{1'b0, A_CTRL,         32'h0,          "rst_ctrl"},
         '{1'b0, A_LOAD,         32'hFFFF_FFFF,  "rst_load"},
         '{1'b0, A_VALUE,        32'hFFFF_FFFF,  "rst_value"},
         '{1'b0, A_STATUS,       32'h0,          "rst_status"},
         '{1'b1, A_LOAD,         32'h1234_5678,  "wr_load"},
         '{1'b0, A_LOAD,         32'h1234_5678,  "load_rb"},
         '{1'b0, A_VALUE,        32'h1234_5678,  "load_to_value"},
         '{1'b1, A_VALUE,        32'h0000_0099,  "wr_value"},
         '{1'b0, A_VALUE,        32'h1234_5678,  "value_ro"},
         '{1'b1, A_CTRL,         32'hFFFF_A5F6,  "wr_ctrl"},
         '{1'b0, A_CTRL,         (HAS_PS ? 32'h0000_A506 : 32'h0000_0006), "ctrl_rb"},
         '{1'b0, 32'hFFFF_FFF5,  32'h1234_5678,  "addr_alias"},
         '{1'b1, A_STATUS,       32'h1,          "wr_status_idle"},
         '{1'b0, A_STATUS,       32'h0,          "status_idle"},
         '{1'b1, A_CTRL,         32'h0,          "ctrl_off"},
         '{1'b0, A_CTRL,         32'h0,          "ctrl_zero"}
      };

      idle();
      Hresetn = 1'b0;
      cyc(3);
      #2 Hresetn = 1'b1;
      cyc(1);
      compare("rst_irq", 32'(Irq), 32'h0);
      compare("rst_prdata_unsel", bus.Prdata, 32'h0);

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
         else           rd(tbl[i].addr, tbl[i].data, tbl[i].name);
      end

      // Setup phase alone must not write.
      bus.Psel = 1'b1; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
      bus.Paddr = A_LOAD; bus.Pwdata = 32'hDEAD_BEEF;
      cyc(2);
      idle();
      rd(A_LOAD, 32'h1234_5678, "setup_only");

      // One-shot, prescale 0
      wr(A_LOAD, 32'd5);
      wr(A_CTRL, 32'h5);
      rd(A_VALUE, 32'd5, "os_v5");
      for (int k = 1; k <= 4; k++) begin
         cyc(1);
         rd(A_VALUE, 32'(5 - k), $sformatf("os_v%0d", 5 - k));
      end
      cyc(1);
      rd(A_VALUE, 32'h0, "os_value0");
      rd(A_STATUS, 32'h1, "os_expired");
      rd(A_CTRL, 32'h4, "os_en_clr");
      compare("os_irq_lag", 32'(Irq), 32'h0);
      cyc(1);
      compare("os_irq", 32'(Irq), 32'h1);

      wr(A_STATUS, 32'h1);
      rd(A_STATUS, 32'h0, "clr_status");
      compare("irq_hold", 32'(Irq), 32'h1);
      cyc(1);
      compare("irq_drop", 32'(Irq), 32'h0);

      // STATUS clear landing on the expiry edge
      wr(A_LOAD, 32'd3);
      wr(A_CTRL, 32'h5);
      cyc(1);
      wr(A_STATUS, 32'h1);
      rd(A_STATUS, 32'h1, "race_set_wins");
      rd(A_VALUE, 32'h0, "race_value0");
      wr(A_STATUS, 32'h1);
      rd(A_STATUS, 32'h0, "late_clear");
      compare("late_irq_hold", 32'(Irq), 32'h1);
      cyc(1);
      compare("late_irq_drop", 32'(Irq), 32'h0);

      // Periodic with prescaler
      wr(A_LOAD, 32'd3);
      wr(A_CTRL, 32'h0000_0303);
      rd(A_CTRL, (HAS_PS ? 32'h0000_0303 : 32'h0000_0003), "per_ctrl");
      for (int k = 1; k <= 6 * P; k++) begin
         cyc(1);
         rd(A_VALUE, 32'(3 - ((k / P) % 3)), $sformatf("per_value_k%0d", k));
         rd(A_STATUS, (k >= 3 * P) ? 32'h1 : 32'h0, $sformatf("per_status_k%0d", k));
      end
      compare("per_irq_masked", 32'(Irq), 32'h0);

      // LOAD write on a tick edge
      wr(A_CTRL, 32'h0000_0303);
      if (P >= 2) cyc(P - 2);
      wr(A_LOAD, 32'h10);
      rd(A_VALUE, 32'h10, "ld_tick_wins");
      rd(A_LOAD, 32'h10, "ld_tick_load");
      if (P > 1) begin
         cyc(P - 1);
         rd(A_VALUE, 32'h10, "ld_ps_restart");
      end
      cyc(1);
      rd(A_VALUE, 32'h0F, "ld_next_dec");

      // Asynchronous reset mid-count
      wr(A_CTRL, 32'h4);
      cyc(1);
      compare("pre_rst_irq", 32'(Irq), 32'h1);
      wr(A_LOAD, 32'd7);
      wr(A_CTRL, 32'h5);
      rd(A_VALUE, 32'd7, "pre_rst_value");
      #2 Hresetn = 1'b0;
      #1;
      rd(A_CTRL,   32'h0,         "arst_ctrl");
      rd(A_LOAD,   32'hFFFF_FFFF, "arst_load");
      rd(A_VALUE,  32'hFFFF_FFFF, "arst_value");
      rd(A_STATUS, 32'h0,         "arst_status");
      compare("arst_irq", 32'(Irq), 32'h0);
      cyc(2);
      #2 Hresetn = 1'b1;
      cyc(2);
      compare("post_rst_prdata", bus.Prdata, 32'h0);
      rd(A_VALUE, 32'hFFFF_FFFF, "post_rst_value");
      compare("post_rst_irq", 32'(Irq), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
